// File: rtl/v_shreg_sched_pkg.sv
// Shared constants for the two-requester serial transmit scheduler.
// State codes stay plain constants so legacy netlists and probes keep matching.
package v_shreg_sched_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DIV   = 4;

    // Counter width must hold values up to max(width, div) - 1 with headroom.
    function automatic int cnt_width(input int width, input int div);
        int m;
        m = (width > div) ? width : div;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/v_shreg_piso.sv
// WIDTH-bit parallel-load, clock-enabled, MSB-first shift register.
// Load has priority over shift; vacated bits fill with zero.
module v_shreg_piso
    import v_shreg_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             shen,
    output logic             so
);

    logic [WIDTH-1:0] shreg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= din;
        end else if (shen) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
        end
    end

    assign so = shreg[WIDTH-1];

endmodule

// File: rtl/v_shift_register_sched.sv
// Round-robin scheduler feeding a prescaled PISO serial output shared by two requesters.
// Arbiter, prescaler, bit counter and IDLE/SHIFT control live here.
module v_shift_register_sched
    import v_shreg_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIV   = DEF_DIV,
    parameter int CNT_W = cnt_width(WIDTH, DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             SO,
    output logic             sclken,
    output logic             busy,
    output logic             done,
    output logic             grant_id
);

    logic [0:0]       state;
    logic [CNT_W-1:0] presc;
    logic [CNT_W-1:0] bitcnt;
    logic             last_grant;
    logic             win;
    logic             accept;
    logic             tick;
    logic             last_bit;
    logic [WIDTH-1:0] load_data;

    // Contention goes to whichever requester was not served last.
    always_comb begin
        win = ~last_grant;
        if (req0_valid && !req1_valid) begin
            win = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            win = 1'b1;
        end
    end

    assign req0_ready = (state == ST_IDLE) && req0_valid && !win;
    assign req1_ready = (state == ST_IDLE) && req1_valid &&  win;
    assign accept     = req0_ready | req1_ready;
    assign load_data  = win ? req1_data : req0_data;

    assign tick     = (state == ST_SHIFT) && (presc == CNT_W'(DIV - 1));
    assign last_bit = tick && (bitcnt == CNT_W'(WIDTH - 1));
    assign sclken   = tick;
    assign busy     = (state == ST_SHIFT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            presc      <= '0;
            bitcnt     <= '0;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= last_bit;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state      <= ST_SHIFT;
                        presc      <= '0;
                        bitcnt     <= '0;
                        last_grant <= win;
                        grant_id   <= win;
                    end
                end
                default: begin
                    if (tick) begin
                        presc  <= '0;
                        bitcnt <= bitcnt + CNT_W'(1);
                        if (last_bit) begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        presc <= presc + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // The register drains to all zeros after the final shift, so SO idles low.
    v_shreg_piso #(
        .WIDTH(WIDTH)
    ) u_piso (
        .clk  (clk),
        .rst_n(rst_n),
        .load (accept),
        .din  (load_data),
        .shen (tick),
        .so   (SO)
    );

endmodule
